// File: rtl/stream_xor_pkg.sv
// rtl/stream_xor_pkg.sv - shared state encoding and default sizing for stream_xor_encrypt
package stream_xor_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WARMUP = 2'd1,
        ST_RUN    = 2'd2,
        ST_DRAIN  = 2'd3
    } state_e;

    localparam int DEF_DEPTH  = 4;
    localparam int DEF_WARMUP = 16;
    localparam int DEF_LEN_W  = 16;

    function automatic logic [31:0] rotl1(input logic [31:0] v);
        return {v[30:0], v[31]};
    endfunction

endpackage

// File: rtl/stream_xor_encrypt_ks_fifo.sv
// rtl/stream_xor_encrypt_ks_fifo.sv - keystream FIFO, first-word-fall-through head
module ks_fifo #(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        push,
    input  logic [31:0] din,
    input  logic        pop,
    output logic [31:0] dout,
    output logic        full,
    output logic        empty
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [31:0]      mem_q [DEPTH];
    logic [PTR_W-1:0] wr_q;
    logic [PTR_W-1:0] rd_q;
    logic [PTR_W:0]   cnt_q;
    logic             do_push;
    logic             do_pop;

    assign full    = (cnt_q == (PTR_W+1)'(DEPTH));
    assign empty   = (cnt_q == '0);
    assign dout    = mem_q[rd_q];
    assign do_pop  = pop & ~empty;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    assign do_push = push & (~full | do_pop);

    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (do_push) wr_q <= wr_q + 1'b1;
            if (do_pop)  rd_q <= rd_q + 1'b1;
            if (do_push && !do_pop)      cnt_q <= cnt_q + 1'b1;
            else if (do_pop && !do_push) cnt_q <= cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_q] <= din;
    end

endmodule

// File: rtl/stream_xor_encrypt.sv
// rtl/stream_xor_encrypt.sv - keystream XOR cipher stage with warm-up discard and keystream FIFO
// Optional running ciphertext tag enabled by STREAM_XOR_TAG_EN.
module stream_xor_encrypt
    import stream_xor_pkg::*;
#(
    parameter int DEPTH  = DEF_DEPTH,
    parameter int WARMUP = DEF_WARMUP,
    parameter int LEN_W  = DEF_LEN_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [LEN_W-1:0] msg_len,
    input  logic [31:0]      ks_word,
    input  logic             ks_valid,
    output logic             ks_ready,
    input  logic [31:0]      pt_data,
    input  logic             pt_valid,
    output logic             pt_ready,
    output logic [31:0]      ct_data,
    output logic             ct_valid,
    input  logic             ct_ready,
    output logic             busy,
    output logic             done,
    output logic             overflow
`ifdef STREAM_XOR_TAG_EN
    ,
    output logic [31:0]      tag
`endif
);

    localparam int WARM_W = (WARMUP > 1) ? $clog2(WARMUP + 1) : 1;

    state_e            state_q;
    logic [LEN_W-1:0]  rem_q;
    logic [WARM_W-1:0] warm_q;
    logic [31:0]       ct_data_q;
    logic [31:0]       ct_data_d;
    logic              ct_valid_q;
    logic              done_q;
    logic              overflow_q;

    logic              start_acc;
    logic              fire;
    logic              fifo_resetn;
    logic              fifo_push;
    logic [31:0]       fifo_dout;
    logic              fifo_full;
    logic              fifo_empty;

    assign start_acc   = (state_q == ST_IDLE) & start;
    // Accepted start flushes any keystream left over from the previous message.
    assign fifo_resetn = reset & ~start_acc;

    assign pt_ready  = (state_q == ST_RUN) & (rem_q != '0) & ~fifo_empty
                     & (~ct_valid_q | ct_ready);
    assign fire      = pt_valid & pt_ready;
    assign fifo_push = (state_q == ST_RUN) & ks_valid & (~fifo_full | fire);
    assign ct_data_d = pt_data ^ fifo_dout;

    assign ks_ready  = ((state_q == ST_RUN) | (state_q == ST_WARMUP)) & ~fifo_full;
    assign busy      = (state_q != ST_IDLE);
    assign ct_data   = ct_data_q;
    assign ct_valid  = ct_valid_q;
    assign done      = done_q;
    assign overflow  = overflow_q;

    ks_fifo #(
        .DEPTH (DEPTH)
    ) u_ks_fifo (
        .clk   (clk),
        .reset (fifo_resetn),
        .push  (fifo_push),
        .din   (ks_word),
        .pop   (fire),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

`ifdef STREAM_XOR_TAG_EN
    logic [31:0] tag_q;
    assign tag = tag_q;
`endif

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            rem_q      <= '0;
            warm_q     <= '0;
            ct_data_q  <= '0;
            ct_valid_q <= 1'b0;
            done_q     <= 1'b0;
            overflow_q <= 1'b0;
`ifdef STREAM_XOR_TAG_EN
            tag_q      <= '0;
`endif
        end else begin
            done_q <= 1'b0;

            if (fire) begin
                ct_data_q  <= ct_data_d;
                ct_valid_q <= 1'b1;
                rem_q      <= rem_q - 1'b1;
`ifdef STREAM_XOR_TAG_EN
                tag_q      <= rotl1(tag_q) ^ ct_data_d;
`endif
            end else if (ct_ready) begin
                ct_valid_q <= 1'b0;
            end

            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        rem_q      <= msg_len;
                        warm_q     <= '0;
                        overflow_q <= 1'b0;
                        state_q    <= ST_WARMUP;
`ifdef STREAM_XOR_TAG_EN
                        tag_q      <= '0;
`endif
                    end
                end
                ST_WARMUP: begin
                    if (WARMUP == 0) begin
                        state_q <= ST_RUN;
                    end else if (ks_valid) begin
                        warm_q <= warm_q + 1'b1;
                        if (warm_q == WARM_W'(WARMUP - 1)) state_q <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (ks_valid && fifo_full && !fire) overflow_q <= 1'b1;
                    if (rem_q == '0) state_q <= ST_DRAIN;
                end
                ST_DRAIN: begin
                    if (!ct_valid_q || ct_ready) begin
                        done_q  <= 1'b1;
                        state_q <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_stream_xor_encrypt.sv
// tb/tb_stream_xor_encrypt.sv - self-checking bench for stream_xor_encrypt
module tb_stream_xor_encrypt;

    localparam int DEPTH  = 4;
    localparam int WARMUP = 16;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [15:0] msg_len;
    logic [31:0] ks_word;
    logic        ks_valid;
    logic        ks_ready;
    logic [31:0] pt_data;
    logic        pt_valid;
    logic        pt_ready;
    logic [31:0] ct_data;
    logic        ct_valid;
    logic        ct_ready;
    logic        busy;
    logic        done;
    logic        overflow;
`ifdef STREAM_XOR_TAG_EN
    logic [31:0] tag;
    logic [31:0] tag_cap [$];
`endif

    int checks = 0;
    int fails  = 0;

    logic [31:0] ks_next = 32'd0;
    logic [31:0] pt_mem [16];
    logic [31:0] ct_cap [$];
    int          done_cnt = 0;

    logic [31:0] m_q [$];
    int          m_phase = 0;
    int          m_rem   = 0;
    int          m_warm  = 0;
    logic        m_ctv   = 1'b0;
    logic [31:0] m_ctd   = '0;
    logic        m_done  = 1'b0;
    logic        m_ovf   = 1'b0;
    logic [31:0] m_tag   = '0;

    always #5 clk = ~clk;

    stream_xor_encrypt #(
        .DEPTH  (DEPTH),
        .WARMUP (WARMUP),
        .LEN_W  (16)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .msg_len  (msg_len),
        .ks_word  (ks_word),
        .ks_valid (ks_valid),
        .ks_ready (ks_ready),
        .pt_data  (pt_data),
        .pt_valid (pt_valid),
        .pt_ready (pt_ready),
        .ct_data  (ct_data),
        .ct_valid (ct_valid),
        .ct_ready (ct_ready),
        .busy     (busy),
        .done     (done),
        .overflow (overflow)
`ifdef STREAM_XOR_TAG_EN
        ,
        .tag      (tag)
`endif
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] cap_at(input int idx);
        if (idx < ct_cap.size()) return ct_cap[idx];
        return 32'hDEAD_BEEF;
    endfunction

    // Reference model: phases, a bounded keystream queue and the ciphertext register.
    always @(negedge clk) begin
        logic        exp_ptr;
        logic        exp_ksr;
        logic        fire;
        logic        ks_push;
        logic [31:0] head;
        exp_ptr = (m_phase == 2) && (m_rem != 0) && (m_q.size() != 0) && (!m_ctv || ct_ready);
        exp_ksr = (m_phase == 1 || m_phase == 2) && (m_q.size() < DEPTH);
        chk("busy", 32'(busy), 32'(m_phase != 0));
        chk("done", 32'(done), 32'(m_done));
        chk("overflow", 32'(overflow), 32'(m_ovf));
        chk("ct_valid", 32'(ct_valid), 32'(m_ctv));
        chk("pt_ready", 32'(pt_ready), 32'(exp_ptr));
        chk("ks_ready", 32'(ks_ready), 32'(exp_ksr));
        if (m_ctv) chk("ct_data", ct_data, m_ctd);
`ifdef STREAM_XOR_TAG_EN
        chk("tag", tag, m_tag);
        if (ct_valid && ct_ready) tag_cap.push_back(tag);
`endif
        if (ct_valid && ct_ready) ct_cap.push_back(ct_data);
        if (done) done_cnt++;

        if (!reset) begin
            m_phase = 0; m_rem = 0; m_warm = 0; m_q.delete();
            m_ctv = 1'b0; m_ctd = '0; m_done = 1'b0; m_ovf = 1'b0; m_tag = '0;
        end else begin
            fire    = pt_valid && exp_ptr;
            ks_push = 1'b0;
            head    = (m_q.size() != 0) ? m_q[0] : 32'd0;
            m_done  = 1'b0;
            case (m_phase)
                0: if (start) begin
                    m_rem = int'(msg_len); m_warm = 0; m_ovf = 1'b0;
                    m_q.delete(); m_tag = '0; m_phase = 1;
                end
                1: if (ks_valid) begin
                    m_warm++;
                    if (m_warm == WARMUP) m_phase = 2;
                end
                2: begin
                    if (ks_valid) begin
                        if (m_q.size() < DEPTH || fire) ks_push = 1'b1;
                        else m_ovf = 1'b1;
                    end
                    if (m_rem == 0) m_phase = 3;
                end
                default: if (!m_ctv || ct_ready) begin
                    m_done = 1'b1; m_phase = 0;
                end
            endcase
            if (fire) begin
                void'(m_q.pop_front());
                m_rem--;
                m_ctv = 1'b1;
                m_ctd = pt_data ^ head;
                m_tag = {m_tag[30:0], m_tag[31]} ^ m_ctd;
            end else if (ct_ready) begin
                m_ctv = 1'b0;
            end
            if (ks_push) m_q.push_back(ks_word);
        end
    end

    task automatic tick_hs(output bit hs);
        @(negedge clk);
        hs = pt_valid && pt_ready;
        @(posedge clk);
        #1;
        ks_word = ks_next;
        ks_next = ks_next + 32'd1;
    endtask

    task automatic tick();
        bit hs;
        tick_hs(hs);
    endtask

    task automatic do_start(input int n);
        msg_len = 16'(n);
        start   = 1'b1;
        ks_next = 32'd0;
        tick();
        start   = 1'b0;
    endtask

    task automatic run_msg(input int n, input bit stall);
        int          i;
        int          cyc;
        int          d0;
        bit          hs;
        bit          stalled;
        logic [31:0] held;
        d0 = done_cnt; i = 0; cyc = 0; stalled = 1'b0;
        if (stall) ct_ready = 1'b0;
        do_start(n);
        if (n > 0) begin
            pt_valid = 1'b1;
            pt_data  = pt_mem[0];
        end
        while (done_cnt == d0 && cyc < 200) begin
            tick_hs(hs);
            cyc++;
            if (hs) begin
                i++;
                if (i < n) pt_data = pt_mem[i];
                else pt_valid = 1'b0;
            end
            if (stall && !stalled && ct_valid) begin
                stalled = 1'b1;
                held    = ct_data;
                repeat (10) begin
                    tick_hs(hs);
                    chk("bp_no_accept", 32'(hs), 32'd0);
                    chk("bp_ct_hold", ct_data, held);
                    chk("bp_ct_valid", 32'(ct_valid), 32'd1);
                end
                chk("bp_overflow", 32'(overflow), 32'd1);
                chk("bp_ks_ready", 32'(ks_ready), 32'd0);
                ct_ready = 1'b1;
            end
        end
        pt_valid = 1'b0;
        chk("done_seen", 32'(done_cnt - d0), 32'd1);
        chk("pt_consumed", 32'(i), 32'(n));
        repeat (3) tick();
        chk("done_once", 32'(done_cnt - d0), 32'd1);
    endtask

    logic [31:0] rt_tab [8] = '{32'h0000_0000, 32'hFFFF_FFFF, 32'hDEAD_BEEF, 32'h0123_4567,
                                32'h89AB_CDEF, 32'h5555_5555, 32'hAAAA_AAAA, 32'h0F0F_0F0F};
    logic [31:0] ct1 [8];

    initial begin
        int  base;
        int  d0;
        int  i;
        int  cyc;
        bit  hs;
        reset = 1'b0; start = 1'b0; msg_len = '0; ks_word = '0; ks_valid = 1'b1;
        pt_data = '0; pt_valid = 1'b0; ct_ready = 1'b1;
        repeat (3) tick();
        chk("rst_ct_data", ct_data, 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_ks_ready", 32'(ks_ready), 32'd0);
        reset = 1'b1;
        tick();

        // Warm-up discard: first used keystream word is 16.
        pt_mem[0] = 32'hFFFF_0000;
        pt_mem[1] = 32'h1234_5678;
        base = ct_cap.size();
        run_msg(2, 1'b0);
        chk("warm_ct0", cap_at(base), 32'hFFFF_0010);
        chk("warm_ct1", cap_at(base + 1), 32'h1234_5669);

        // Backpressure with FIFO fill and overflow.
        for (int k = 0; k < 6; k++) pt_mem[k] = 32'h1000_0000 * k + 32'h0000_0F0F;
        base = ct_cap.size();
        run_msg(6, 1'b1);
        chk("bp_ct0", cap_at(base), 32'h0000_0F0F ^ 32'd16);
        chk("bp_count", 32'(ct_cap.size() - base), 32'd6);

        // Zero-length message.
        base = ct_cap.size();
        run_msg(0, 1'b0);
        chk("m0_no_ct", 32'(ct_cap.size() - base), 32'd0);

        // Reset in the middle of RUN.
        for (int k = 0; k < 8; k++) pt_mem[k] = 32'hC0DE_0000 + k;
        d0 = done_cnt; base = ct_cap.size();
        do_start(8);
        pt_valid = 1'b1; pt_data = pt_mem[0]; i = 0; cyc = 0;
        while (ct_cap.size() < base + 3 && cyc < 100) begin
            tick_hs(hs);
            cyc++;
            if (hs) begin
                i++;
                pt_data = pt_mem[i];
            end
        end
        chk("rr_three_words", 32'(ct_cap.size() - base), 32'd3);
        reset = 1'b0; pt_valid = 1'b0;
        tick();
        reset = 1'b1;
        chk("rr_ct_valid", 32'(ct_valid), 32'd0);
        chk("rr_ct_data", ct_data, 32'd0);
        chk("rr_busy", 32'(busy), 32'd0);
        chk("rr_pt_ready", 32'(pt_ready), 32'd0);
        chk("rr_ks_ready", 32'(ks_ready), 32'd0);
        chk("rr_overflow", 32'(overflow), 32'd0);
        chk("rr_done", 32'(done), 32'd0);
        repeat (20) tick();
        chk("rr_no_done", 32'(done_cnt - d0), 32'd0);
        base = ct_cap.size();
        run_msg(2, 1'b0);
        chk("rr_fresh_ct0", cap_at(base), 32'hC0DE_0000 ^ 32'd16);

        // Round trip: ciphertext re-encrypted with the same keystream gives plaintext.
        for (int k = 0; k < 8; k++) pt_mem[k] = rt_tab[k];
        base = ct_cap.size();
        run_msg(8, 1'b0);
        for (int k = 0; k < 8; k++) ct1[k] = cap_at(base + k);
        chk("rt_ct0", ct1[0], 32'h0000_0010);
        chk("rt_ct2", ct1[2], 32'hDEAD_BEEF ^ 32'd18);
        for (int k = 0; k < 8; k++) pt_mem[k] = ct1[k];
        base = ct_cap.size();
        run_msg(8, 1'b0);
        for (int k = 0; k < 8; k++) chk($sformatf("rt_pt%0d", k), cap_at(base + k), rt_tab[k]);

        // Ciphertext words 1 then 2.
        pt_mem[0] = 32'd17;
        pt_mem[1] = 32'd19;
        base = ct_cap.size();
        run_msg(2, 1'b0);
        chk("tagmsg_ct0", cap_at(base), 32'd1);
        chk("tagmsg_ct1", cap_at(base + 1), 32'd2);
`ifdef STREAM_XOR_TAG_EN
        chk("tag_after_1", (base < tag_cap.size()) ? tag_cap[base] : 32'hDEAD_BEEF, 32'd1);
        chk("tag_after_2", (base + 1 < tag_cap.size()) ? tag_cap[base + 1] : 32'hDEAD_BEEF, 32'd0);
        chk("tag_final", tag, 32'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog expired checks=%0d failures=%0d", checks, fails);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/stream_xor_encrypt.md
Name: stream_xor_encrypt

Overview:
- Consumes the 32-bit keystream produced by the chaotic-map stream cipher core and XORs it word-by-word with a plaintext stream to produce ciphertext. Decryption is the same operation.
- Sits directly downstream of the cipher core's keystream output.
- Contains:
  - a warm-up discard counter for the first keystream words after start;
  - a small keystream FIFO, which decouples the free-running generator from plaintext backpressure;
  - a registered valid/ready ciphertext output and a message-length word counter.

Parameters:
- DEPTH, 4, keystream FIFO entries; power of two, minimum 2.
- WARMUP, 16, keystream words discarded after start before any word is used.
- LEN_W, 16, width of the message-length word count.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- reset  in  1  synchronous, active-low reset.
- start  in  1  one-cycle pulse; begins a message. Ignored unless state is IDLE.
- msg_len  in  LEN_W  plaintext words in the message; sampled when start is accepted. A value of 0 finishes immediately.
- ks_word  in  32  keystream word from the cipher core.
- ks_valid  in  1  ks_word is a fresh keystream word this cycle.
- ks_ready  out  1  FIFO not full; advisory enable for the generator.
- pt_data  in  32  plaintext word.
- pt_valid  in  1  pt_data valid.
- pt_ready  out  1  plaintext accepted this cycle when pt_valid=1.
- ct_data  out  32  ciphertext word (registered).
- ct_valid  out  1  ct_data valid.
- ct_ready  in  1  downstream accepts ct_data.
- busy  out  1  state is not IDLE.
- done  out  1  one-cycle pulse when the last ciphertext word is accepted downstream.
- overflow  out  1  sticky flag: ks_valid arrived while FIFO full in RUN; the word was dropped. Cleared by reset or start.

Behaviour:
- Reset (reset=0 at a clk edge) puts every output and register to 0:
  - state=IDLE, FIFO empty, counters 0;
  - ct_data=0, ct_valid=0, pt_ready=0, ks_ready=0, busy=0, done=0, overflow=0.
  - Reset mid-message aborts immediately; no done pulse.
- FSM states IDLE, WARMUP, RUN, DRAIN:
  - IDLE: on start, latch msg_len, clear the FIFO, the warm-up count and overflow, then go to WARMUP.
  - WARMUP: each ks_valid cycle increments the discard count and writes nothing to the FIFO. After the WARMUP-th word go to RUN. If WARMUP=0, go straight to RUN.
  - RUN: ks_valid with FIFO not full pushes ks_word; with FIFO full it is dropped and overflow set. When the remaining count reaches 0, go to DRAIN.
  - DRAIN: wait until ct_valid=0 or the final word handshakes, then pulse done and return to IDLE.
- Plaintext handshake, RUN only:
  - pt_ready = (remaining count != 0) & FIFO not empty & (ct_valid=0 | ct_ready=1).
  - On a pt_valid & pt_ready cycle:
    - ct_data <= pt_data ^ FIFO head;
    - FIFO pops;
    - ct_valid <= 1;
    - remaining count decrements.
- Latency: one cycle from plaintext acceptance to ct_valid.
- ct_valid clears when ct_ready=1 and no new word is loaded that cycle. ct_data holds while ct_valid=1 & ct_ready=0.
- Push and pop in the same cycle are allowed with the FIFO full: the count is unchanged and there is no overflow.
- FIFO pointers are log2(DEPTH) bits and wrap modulo DEPTH. The count is log2(DEPTH)+1 bits.
- ks_ready = state is RUN or WARMUP and FIFO not full.
- msg_len=0: WARMUP still runs, RUN goes immediately to DRAIN, and done pulses 1 cycle later.
- start while busy is ignored.

Optional Feature:
- Macro STREAM_XOR_TAG_EN.
- When defined:
  - adds output port tag [31:0];
  - tag resets to 0 and clears on accepted start;
  - on each ciphertext load, tag <= {tag[30:0],tag[31]} ^ new ct word;
  - tag is stable and valid in the done cycle.
- When undefined: no tag port and no tag logic.

Decomposition:
- Shared package stream_xor_pkg holds:
  - state encoding constants IDLE=2'd0, WARMUP=2'd1, RUN=2'd2, DRAIN=2'd3;
  - the default DEPTH, WARMUP and LEN_W values.
- One sub-module: ks_fifo (synchronous FIFO).
  - Parameter DEPTH; ports clk, reset, push, din, pop, dout, full, empty.
  - First-word-fall-through head.

Test Plan:
- Warm-up discard: WARMUP=16, msg_len=2, ks_word=counter value. Required: the first ciphertext uses ks_word 16. pt 0xFFFF0000 -> ct 0xFFFF0010.
- Backpressure: hold ct_ready=0 for 10 cycles with DEPTH=4 and a continuous keystream. Required: ct_data stable, pt_ready=0, ks_ready=0 once FIFO full, then overflow=1 on the next ks_valid.
- msg_len=0: start with no plaintext. Required: done pulses once after WARMUP keystream words; no ct_valid ever.
- Reset mid-RUN: after 3 of 8 words, pull reset low 1 cycle. Required: all outputs 0, state IDLE, no done; a fresh start works normally.
- Round trip: encrypt 8 words, re-run with same keystream sequence and ciphertext as input. Required: output equals the original plaintext.
- With STREAM_XOR_TAG_EN, ct words 1 then 2. Required: tag 0x00000001 after the first word, then 0x00000000 after the second (rotate gives 2, 2^2=0).
